// File: rtl/serial_msg_transmitter_pkg.sv
// Shared framing definitions for the serial message link: type codes, TYPE/SYNC bytes,
// default payload lengths and the byte-state FSM encoding.
package serial_msg_transmitter_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0] MSG_PARTICLE = 2'd0;
  localparam logic [1:0] MSG_MAP      = 2'd1;

  localparam byte_t TYPE_PARTICLE_BYTE = 8'h50;
  localparam byte_t TYPE_MAP_BYTE      = 8'h4D;
  localparam byte_t DEFAULT_SYNC_BYTE  = 8'h46;

  localparam int DEFAULT_PARTICLE_LEN = 16;
  localparam int DEFAULT_MAP_LEN      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_TYPE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } tx_state_t;

  typedef struct packed {
    byte_t type_byte;
    byte_t len;
  } meta_t;

  // Checksum byte that makes TYPE + LEN + payload + CSUM sum to zero mod 256.
  function automatic byte_t csum_finish(input byte_t acc);
    return 8'(8'd0 - acc);
  endfunction

endpackage

// File: rtl/serial_msg_transmitter_if.sv
// Byte stream towards the UART transmitter: one byte moves per tx_valid && tx_ready cycle.
interface serial_msg_transmitter_if;
  import serial_msg_transmitter_pkg::*;

  byte_t tx_data;
  logic  tx_valid;
  logic  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_msg_transmitter_fifo.sv
// Synchronous first-word-fall-through byte FIFO; count/full registered, head visible combinationally.
// Push is accepted when not full, or when full and a pop happens in the same cycle.
module msg_tx_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_msg_transmitter.sv
// Frames buffered payload bytes as SYNC, TYPE, LEN, payload, CSUM and streams them to the UART.
// Start accepted in one cycle; no bubbles between bytes; each byte held until tx_ready.
module serial_msg_transmitter
  import serial_msg_transmitter_pkg::*;
#(
  parameter int    PARTICLE_MSG_LEN = DEFAULT_PARTICLE_LEN,
  parameter int    MAP_MSG_LEN      = DEFAULT_MAP_LEN,
  parameter int    FIFO_DEPTH       = 32,
  parameter byte_t SYNC_BYTE        = DEFAULT_SYNC_BYTE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      wr_data,
  input  logic                            wr_en,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  input  logic                            msg_start,
  input  logic [1:0]                      msg_type,
  serial_msg_transmitter_if.master        tx,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);
  localparam byte_t P_LEN = 8'(PARTICLE_MSG_LEN);
  localparam byte_t M_LEN = 8'(MAP_MSG_LEN);

  tx_state_t state;
  tx_state_t state_nxt;
  meta_t     meta;
  meta_t     sel_meta;
  byte_t     acc;
  byte_t     cnt;
  byte_t     fifo_head;
  byte_t     tx_dat;
  logic      fifo_empty;
  logic      type_ok;
  logic      start_ok;
  logic      tx_vld;
  logic      pop;
  logic      accept;
  logic      reject;
  logic      fin;

  msg_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    sel_meta = '{type_byte: TYPE_PARTICLE_BYTE, len: P_LEN};
    type_ok  = 1'b1;
    case (msg_type)
      MSG_PARTICLE: sel_meta = '{type_byte: TYPE_PARTICLE_BYTE, len: P_LEN};
      MSG_MAP:      sel_meta = '{type_byte: TYPE_MAP_BYTE, len: M_LEN};
      default:      type_ok  = 1'b0;
    endcase
  end

  // Registered count only: a byte pushed alongside msg_start does not qualify it.
  assign start_ok = type_ok && !fifo_empty && (32'(fifo_count) >= 32'(sel_meta.len));

  always_comb begin
    state_nxt = state;
    tx_vld    = 1'b0;
    tx_dat    = 8'h00;
    pop       = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (msg_start) begin
          if (start_ok) begin
            accept    = 1'b1;
            state_nxt = ST_SYNC;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_SYNC: begin
        tx_vld = 1'b1;
        tx_dat = SYNC_BYTE;
        if (tx.tx_ready) state_nxt = ST_TYPE;
      end
      ST_TYPE: begin
        tx_vld = 1'b1;
        tx_dat = meta.type_byte;
        if (tx.tx_ready) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        tx_vld = 1'b1;
        tx_dat = meta.len;
        if (tx.tx_ready) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        tx_vld = 1'b1;
        tx_dat = fifo_head;
        if (tx.tx_ready) begin
          pop = 1'b1;
          if (cnt == 8'd1) state_nxt = ST_CSUM;
        end
      end
      ST_CSUM: begin
        tx_vld = 1'b1;
        tx_dat = csum_finish(acc);
        if (tx.tx_ready) begin
          fin       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta  <= '0;
      acc   <= 8'h00;
      cnt   <= 8'h00;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= fin;
      error <= reject;
      if (accept) begin
        meta <= sel_meta;
        cnt  <= sel_meta.len;
        acc  <= 8'h00;
      end else if (tx.tx_ready && (state == ST_TYPE || state == ST_LEN || state == ST_PAYLOAD)) begin
        acc <= acc + tx_dat;
      end
      if (pop) cnt <= cnt - 8'd1;
    end
  end

  assign tx.tx_valid = tx_vld;
  assign tx.tx_data  = tx_dat;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_msg_transmitter.sv
// Randomized scoreboard bench for serial_msg_transmitter: a queue model of the FIFO builds expected frames.
module tb_serial_msg_transmitter;
  localparam int PLEN  = 16;
  localparam int MLEN  = 32;
  localparam int DEPTH = 32;
  localparam logic [7:0] SYNC = 8'h46;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       fifo_full;
  logic [5:0] fifo_count;
  logic       msg_start = 1'b0;
  logic [1:0] msg_type = 2'd0;
  logic       busy;
  logic       done;
  logic       error;

  serial_msg_transmitter_if tx();

  serial_msg_transmitter #(
    .PARTICLE_MSG_LEN (PLEN),
    .MAP_MSG_LEN      (MLEN),
    .FIFO_DEPTH       (DEPTH),
    .SYNC_BYTE        (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .msg_start  (msg_start),
    .msg_type   (msg_type),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    bit         is_pay;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  exp_t       mon_e;
  int unsent = 0, done_exp = 0, done_seen = 0, err_exp = 0, err_seen = 0;
  int hs_total = 0, checks = 0, passes = 0, ready_mode = 0;
  bit held = 0;
  logic [7:0] held_dat;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
  endtask

  initial begin
    tx.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx.tx_ready = 1'b1;
        1:       tx.tx_ready = ~tx.tx_ready;
        2:       tx.tx_ready = ($urandom_range(0, 2) != 0);
        default: tx.tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted byte is compared with the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      held = 0;
    end else begin
      if (tx.tx_valid) begin
        if (held) check("hold_stable", tx.tx_data, held_dat);
        if (tx.tx_ready) begin
          hs_total++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", tx.tx_data, -1);
          end else begin
            mon_e = exp_q.pop_front();
            check("tx_byte", tx.tx_data, mon_e.dat);
            if (mon_e.is_pay) unsent--;
          end
          held = 0;
        end else begin
          held     = 1;
          held_dat = tx.tx_data;
        end
      end else begin
        if (held) check("valid_dropped", 0, 1);
        held = 0;
      end
      if (done) begin
        done_seen++;
        check("done_after_last_byte", exp_q.size(), 0);
      end
      if (error) err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int occ();
    return mq.size() + unsent;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    if (!(unsent > 0 && occ() >= DEPTH)) begin
      if (occ() < DEPTH) mq.push_back(b);
      wr_en   = 1'b1;
      wr_data = b;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic expect_frame(input logic [1:0] t);
    int len;
    int sum;
    logic [7:0] tb;
    logic [7:0] b;
    len = (t == 2'd0) ? PLEN : MLEN;
    tb  = (t == 2'd0) ? 8'h50 : 8'h4D;
    exp_q.push_back('{SYNC, 1'b0});
    exp_q.push_back('{tb, 1'b0});
    exp_q.push_back('{8'(len), 1'b0});
    sum = int'(tb) + len;
    for (int i = 0; i < len; i++) begin
      b = mq.pop_front();
      sum += int'(b);
      exp_q.push_back('{b, 1'b1});
    end
    exp_q.push_back('{8'((256 - (sum % 256)) % 256), 1'b0});
    unsent += len;
    done_exp++;
  endtask

  task automatic start_msg(input logic [1:0] t, input bit also_push, input logic [7:0] pb);
    int len;
    bit ok;
    bit push_ok;
    len     = (t == 2'd0) ? PLEN : ((t == 2'd1) ? MLEN : 0);
    ok      = (t < 2'd2) && (mq.size() >= len);
    push_ok = also_push && (occ() < DEPTH);
    msg_start = 1'b1;
    msg_type  = t;
    if (also_push) begin
      wr_en   = 1'b1;
      wr_data = pb;
    end
    if (ok) expect_frame(t);
    else err_exp++;
    if (push_ok) mq.push_back(pb);
    tick();
    msg_start = 1'b0;
    wr_en     = 1'b0;
    @(negedge clk);
    if (ok) begin
      check("start_busy", busy, 1);
      check("start_valid", tx.tx_valid, 1);
    end else begin
      check("reject_error", error, 1);
      check("reject_no_valid", tx.tx_valid, 0);
    end
    tick();
  endtask

  task automatic wait_frames(input string name);
    int budget;
    budget = 3000;
    while (done_seen < done_exp && budget > 0) begin
      tick();
      budget--;
    end
    check(name, done_seen, done_exp);
    tick();
  endtask

  task automatic busy_traffic(input bit allow_push, input bit allow_start);
    int budget;
    int r;
    budget = 3000;
    while (done_seen < done_exp && budget > 0) begin
      r = $urandom_range(0, 3);
      if (r == 0 && allow_push) begin
        push_byte(8'($urandom));
      end else if (r == 1 && allow_start && exp_q.size() > 2) begin
        msg_start = 1'b1;
        msg_type  = 2'($urandom_range(0, 3));
        tick();
        msg_start = 1'b0;
      end else begin
        tick();
      end
      budget--;
    end
  endtask

  initial begin
    int n;
    int base;
    int budget;
    logic [1:0] t;

    repeat (3) tick();
    @(negedge clk);
    check("rst_tx_data", tx.tx_data, 0);
    check("rst_tx_valid", tx.tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_fifo_count", fifo_count, 0);
    tick();
    reset = 1'b1;
    tick();

    // Particle frame 1..16 with tx_ready held high: 20 back-to-back bytes.
    ready_mode = 0;
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    check("count_after_16", fifo_count, 16);
    start_msg(2'd0, 1'b0, 8'h00);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("frame_cycles", n, 20);
    check("done_pulse", done, 1);
    check("tx_valid_after_done", tx.tx_valid, 0);
    tick();
    check("count_after_frame", fifo_count, 0);
    wait_frames("frame1_done");

    // Same frame with tx_ready toggling.
    ready_mode = 1;
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    start_msg(2'd0, 1'b0, 8'h00);
    wait_frames("frame_toggle_done");

    // Rejections: too little data, invalid types.
    ready_mode = 0;
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    start_msg(2'd0, 1'b0, 8'h00);
    check("reject_count_kept", fifo_count, 10);
    start_msg(2'd3, 1'b0, 8'h00);
    start_msg(2'd2, 1'b0, 8'h00);
    check("reject_count_kept2", fifo_count, 10);

    // Fill to full, drop the 33rd push, then a map frame with pushes during transmit.
    for (int i = 0; i < 23; i++) begin
      push_byte(8'($urandom));
      if (i == 20) check("not_full_at_31", fifo_full, 0);
      if (i == 21) check("full_at_32", fifo_full, 1);
    end
    check("count_capped", fifo_count, 32);
    check("full_after_33", fifo_full, 1);
    ready_mode = 2;
    start_msg(2'd1, 1'b1, 8'($urandom));
    busy_traffic(1'b1, 1'b0);
    wait_frames("map_frame_done");
    check("count_after_map", fifo_count, mq.size());
    while (mq.size() < PLEN) push_byte(8'($urandom));
    start_msg(2'd0, 1'b0, 8'h00);
    busy_traffic(1'b1, 1'b0);
    wait_frames("wrap_frame_done");

    // Reset in the middle of the payload.
    ready_mode = 0;
    while (mq.size() < PLEN) push_byte(8'($urandom));
    base = hs_total;
    start_msg(2'd0, 1'b0, 8'h00);
    budget = 200;
    while (hs_total - base < 7 && budget > 0) begin
      tick();
      budget--;
    end
    check("reach_payload", hs_total - base, 7);
    reset      = 1'b0;
    ready_mode = 3;
    tick();
    reset = 1'b1;
    exp_q.delete();
    mq.delete();
    unsent = 0;
    done_exp--;
    @(negedge clk);
    check("mid_rst_tx_valid", tx.tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    tick();
    ready_mode = 0;
    for (int i = 0; i < PLEN; i++) push_byte(8'($urandom));
    start_msg(2'd0, 1'b0, 8'h00);
    wait_frames("post_reset_frame");

    // Starts while busy must be ignored.
    ready_mode = 1;
    for (int i = 0; i < PLEN; i++) push_byte(8'($urandom));
    start_msg(2'd0, 1'b0, 8'h00);
    busy_traffic(1'b0, 1'b1);
    wait_frames("ignored_start_frame");

    // Random frames.
    for (int it = 0; it < 15; it++) begin
      ready_mode = $urandom_range(0, 2);
      n = $urandom_range(0, DEPTH - occ());
      repeat (n) push_byte(8'($urandom));
      t = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      start_msg(t, 1'($urandom_range(0, 1)), 8'($urandom));
      busy_traffic(1'b1, 1'b1);
      wait_frames("rand_frame_done");
      check("rand_fifo_count", fifo_count, mq.size());
    end

    repeat (3) tick();
    check("total_done", done_seen, done_exp);
    check("total_error", err_seen, err_exp);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
